// File: rtl/instruction_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_fetch_pkg
//  Description : Shared constants, BTB counter encodings and the saturating
//                counter helper used by the fetch stage and its BTB.
//  Revision    : 1.0  initial release
// ============================================================================
package instruction_fetch_pkg;

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam logic [31:0] RESET_PC    = 32'h0000_0000;
    // IF/ID PC value while in reset: one word "before" the reset PC
    localparam logic [31:0] RESET_IFID_PC = 32'hFFFF_FFFC;
    localparam int          BTB_ENTRIES = 16;
    localparam int          BTB_INDEX_W = 4;
    // Tag covers everything above the index and the byte offset
    localparam int          BTB_TAG_W   = 32 - BTB_INDEX_W - 2;

    // 2-bit direction counter; MSB set means "predict taken"
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } btb_ctr_e;

    // Saturating increment on taken, decrement on not taken
    function automatic btb_ctr_e ctr_next(input btb_ctr_e c, input logic taken);
        btb_ctr_e r;
        r = c;
        case (c)
            SNT: r = taken ? WNT : SNT;
            WNT: r = taken ? WT  : SNT;
            WT:  r = taken ? ST  : WNT;
            ST:  r = taken ? ST  : WT;
            default: r = WNT;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_target_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : branch_target_buffer
//  Description : 16-entry direct-mapped BTB with 2-bit saturating direction
//                counters. One combinational lookup port (returns contents as
//                they stand before any same-cycle update) and one update port.
//  Revision    : 1.0  initial release
// ============================================================================
module branch_target_buffer
    import instruction_fetch_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] lookup_pc_i,
    output logic        lookup_taken_o,
    output logic [31:0] lookup_target_o,
    input  logic        upd_en_i,
    input  logic [31:0] upd_pc_i,
    input  logic [31:0] upd_target_i,
    input  logic        upd_taken_i
);

    logic                 valid_q  [BTB_ENTRIES];
    logic [BTB_TAG_W-1:0] tag_q    [BTB_ENTRIES];
    logic [31:0]          target_q [BTB_ENTRIES];
    btb_ctr_e             ctr_q    [BTB_ENTRIES];

    logic [BTB_INDEX_W-1:0] lk_idx;
    logic [BTB_TAG_W-1:0]   lk_tag;
    logic [BTB_INDEX_W-1:0] up_idx;
    logic [BTB_TAG_W-1:0]   up_tag;
    logic                   up_hit;
    logic                   unused_lsb;

    assign lk_idx = lookup_pc_i[BTB_INDEX_W+1:2];
    assign lk_tag = lookup_pc_i[31:BTB_INDEX_W+2];
    assign up_idx = upd_pc_i[BTB_INDEX_W+1:2];
    assign up_tag = upd_pc_i[31:BTB_INDEX_W+2];
    // Instructions are word aligned; byte offset carries no information
    assign unused_lsb = ^{lookup_pc_i[1:0], upd_pc_i[1:0]};

    // Lookup reads registered state, so a same-cycle update is not visible
    assign lookup_taken_o  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag) && ctr_q[lk_idx][1];
    assign lookup_target_o = target_q[lk_idx];

    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    // Train on hit, (re)allocate on miss; independent of pipeline stalls
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= WNT;
            end
        end else if (upd_en_i) begin
            if (up_hit) begin
                ctr_q[up_idx] <= ctr_next(ctr_q[up_idx], upd_taken_i);
                if (upd_taken_i) begin
                    target_q[up_idx] <= upd_target_i;
                end
            end else begin
                valid_q[up_idx]  <= 1'b1;
                tag_q[up_idx]    <= up_tag;
                target_q[up_idx] <= upd_target_i;
                ctr_q[up_idx]    <= upd_taken_i ? WT : WNT;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_fetch
//  Description : Fetch stage: PC register, next-PC selection (redirect, stall,
//                prediction, sequential) and the IF/ID pipeline register.
//                Define BRANCH_PREDICTION_EN to include the BTB predictor;
//                otherwise fetch always predicts fall-through (pc + 4).
//  Revision    : 1.0  initial release
// ============================================================================
module instruction_fetch
    import instruction_fetch_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] imem_addr_if_o,
    input  logic [31:0] imem_data_if_i,
    input  logic        load_stall_if_i,
    input  logic        peripheral_stall_if_i,
    input  logic        branching_if_i,
    input  logic [31:0] branch_target_if_i,
    input  logic        btb_update_en_if_i,
    input  logic [31:0] btb_update_pc_if_i,
    input  logic [31:0] btb_update_target_if_i,
    input  logic        btb_update_taken_if_i,
    output logic [31:0] fetched_instruction_if_o,
    output logic [31:0] pc_if_o,
    output logic [31:0] btb_predicted_pc_if_o,
    output logic        branch_is_taken_prediction_if_o
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4;
    logic        stall;
    logic        pred_taken;
    logic [31:0] pred_pc;

    assign imem_addr_if_o = pc_q;
    assign pc_plus4       = pc_q + 32'd4;
    assign stall          = load_stall_if_i | peripheral_stall_if_i;

`ifdef BRANCH_PREDICTION_EN
    logic [31:0] btb_target;

    branch_target_buffer u_btb (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .lookup_pc_i     (pc_q),
        .lookup_taken_o  (pred_taken),
        .lookup_target_o (btb_target),
        .upd_en_i        (btb_update_en_if_i),
        .upd_pc_i        (btb_update_pc_if_i),
        .upd_target_i    (btb_update_target_if_i),
        .upd_taken_i     (btb_update_taken_if_i)
    );

    assign pred_pc = pred_taken ? btb_target : pc_plus4;
`else
    logic unused_btb_update;

    assign pred_taken = 1'b0;
    assign pred_pc    = pc_plus4;
    // Update port kept for a stable interface; nothing consumes it here
    assign unused_btb_update = ^{btb_update_en_if_i, btb_update_pc_if_i,
                                 btb_update_target_if_i, btb_update_taken_if_i};
`endif

    // Next-PC select: redirect beats stall beats prediction
    always_comb begin
        pc_d = pc_plus4;
        if (branching_if_i) begin
            pc_d = branch_target_if_i;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (pred_taken) begin
            pc_d = pred_pc;
        end
    end

    // PC register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // IF/ID register: bubble on redirect, freeze on stall, else capture fetch
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetched_instruction_if_o        <= NOP_INSTR;
            pc_if_o                         <= RESET_IFID_PC;
            btb_predicted_pc_if_o           <= 32'h0;
            branch_is_taken_prediction_if_o <= 1'b0;
        end else if (branching_if_i) begin
            fetched_instruction_if_o        <= NOP_INSTR;
            pc_if_o                         <= pc_q;
            btb_predicted_pc_if_o           <= pc_plus4;
            branch_is_taken_prediction_if_o <= 1'b0;
        end else if (!stall) begin
            fetched_instruction_if_o        <= imem_data_if_i;
            pc_if_o                         <= pc_q;
            btb_predicted_pc_if_o           <= pred_pc;
            branch_is_taken_prediction_if_o <= pred_taken;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_fetch
//  Description : Directed self-checking bench for instruction_fetch. Expected
//                prediction results depend on BRANCH_PREDICTION_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_instruction_fetch;

`ifdef BRANCH_PREDICTION_EN
    localparam bit BP = 1'b1;
`else
    localparam bit BP = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        load_stall = 1'b0;
    logic        periph_stall = 1'b0;
    logic        branching = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        upd_en = 1'b0;
    logic [31:0] upd_pc = 32'h0;
    logic [31:0] upd_target = 32'h0;
    logic        upd_taken = 1'b0;
    logic [31:0] fetched;
    logic [31:0] pc_if;
    logic [31:0] pred_pc;
    logic        pred_taken;

    int n_checks = 0;
    int n_fail   = 0;

    // Instruction memory model: word content is the inverted address
    assign imem_data = ~imem_addr;

    always #5 clk_i = ~clk_i;

    instruction_fetch dut (
        .clk_i                           (clk_i),
        .rst_i                           (rst_i),
        .imem_addr_if_o                  (imem_addr),
        .imem_data_if_i                  (imem_data),
        .load_stall_if_i                 (load_stall),
        .peripheral_stall_if_i           (periph_stall),
        .branching_if_i                  (branching),
        .branch_target_if_i              (branch_target),
        .btb_update_en_if_i              (upd_en),
        .btb_update_pc_if_i              (upd_pc),
        .btb_update_target_if_i          (upd_target),
        .btb_update_taken_if_i           (upd_taken),
        .fetched_instruction_if_o        (fetched),
        .pc_if_o                         (pc_if),
        .btb_predicted_pc_if_o           (pred_pc),
        .branch_is_taken_prediction_if_o (pred_taken)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic redirect(input logic [31:0] tgt);
        branching     = 1'b1;
        branch_target = tgt;
        tick();
        branching     = 1'b0;
    endtask

    task automatic btb_upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
        upd_en     = 1'b1;
        upd_pc     = pc;
        upd_target = tgt;
        upd_taken  = tk;
        tick();
        upd_en     = 1'b0;
    endtask

    // Redirect to pc, then fetch it once and check the IF/ID prediction
    task automatic fetch_check(input string tag, input logic [31:0] pc, input logic [31:0] bp_tgt,
                               input logic bp_taken);
        logic [31:0] exp_pred;
        logic        exp_tk;
        exp_tk   = BP && bp_taken;
        exp_pred = exp_tk ? bp_tgt : pc + 32'd4;
        redirect(pc);
        tick();
        check_eq({tag, "_pc_if"}, pc_if, pc);
        check_eq({tag, "_instr"}, fetched, ~pc);
        check_eq({tag, "_pred_pc"}, pred_pc, exp_pred);
        check_eq({tag, "_taken"}, {31'h0, pred_taken}, {31'h0, exp_tk});
        check_eq({tag, "_next_addr"}, imem_addr, exp_pred);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick();
        tick();
        check_eq("rst_addr", imem_addr, 32'h0);
        check_eq("rst_instr", fetched, 32'h0000_0013);
        check_eq("rst_pc_if", pc_if, 32'hFFFF_FFFC);
        check_eq("rst_pred", pred_pc, 32'h0);
        check_eq("rst_taken", {31'h0, pred_taken}, 32'h0);
        rst_i = 1'b0;

        // Straight-line fetch
        tick();
        check_eq("seq1_addr", imem_addr, 32'h4);
        check_eq("seq1_pc_if", pc_if, 32'h0);
        check_eq("seq1_instr", fetched, ~32'h0);
        check_eq("seq1_pred", pred_pc, 32'h4);
        tick();
        check_eq("seq2_addr", imem_addr, 32'h8);
        check_eq("seq2_pc_if", pc_if, 32'h4);
        tick();
        tick();
        check_eq("seq4_addr", imem_addr, 32'h10);
        check_eq("seq4_pc_if", pc_if, 32'hC);

        // Load-use stall for two cycles at 0x10
        load_stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_eq("stall_addr", imem_addr, 32'h10);
            check_eq("stall_pc_if", pc_if, 32'hC);
            check_eq("stall_instr", fetched, ~32'hC);
            check_eq("stall_pred", pred_pc, 32'h10);
        end
        load_stall = 1'b0;
        tick();
        check_eq("resume_addr", imem_addr, 32'h14);
        check_eq("resume_pc_if", pc_if, 32'h10);
        check_eq("resume_instr", fetched, ~32'h10);

        // Redirect wins over a peripheral stall
        periph_stall = 1'b1;
        redirect(32'h200);
        periph_stall = 1'b0;
        check_eq("redir_addr", imem_addr, 32'h200);
        check_eq("redir_instr", fetched, 32'h0000_0013);
        check_eq("redir_pc_if", pc_if, 32'h14);
        check_eq("redir_pred", pred_pc, 32'h18);
        check_eq("redir_taken", {31'h0, pred_taken}, 32'h0);

        // Allocate 0x40 -> 0x100 taken (counter 10) and predict it
        btb_upd(32'h40, 32'h100, 1'b1);
        fetch_check("bp_alloc", 32'h40, 32'h100, 1'b1);

        // Two not-taken updates under stall: 10 -> 01 -> 00
        load_stall = 1'b1;
        btb_upd(32'h40, 32'h300, 1'b0);
        btb_upd(32'h40, 32'h300, 1'b0);
        load_stall = 1'b0;
        fetch_check("bp_nt", 32'h40, 32'h0, 1'b0);

        // One taken update from 00 only reaches 01: still not taken
        btb_upd(32'h40, 32'h180, 1'b1);
        fetch_check("bp_weak", 32'h40, 32'h0, 1'b0);
        // Second taken update reaches 10 with the new target
        btb_upd(32'h40, 32'h180, 1'b1);
        fetch_check("bp_retrain", 32'h40, 32'h180, 1'b1);

        // Aliasing: 0x80 shares the index with 0x40 but has a different tag
        fetch_check("alias_miss", 32'h80, 32'h0, 1'b0);
        btb_upd(32'h80, 32'h500, 1'b1);
        fetch_check("alias_new", 32'h80, 32'h500, 1'b1);
        fetch_check("alias_evict", 32'h40, 32'h0, 1'b0);

        // Reset asserted mid-cycle during stall and redirect
        load_stall    = 1'b1;
        branching     = 1'b1;
        branch_target = 32'h700;
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check_eq("rst2_addr", imem_addr, 32'h0);
        check_eq("rst2_instr", fetched, 32'h0000_0013);
        check_eq("rst2_pc_if", pc_if, 32'hFFFF_FFFC);
        tick();
        load_stall = 1'b0;
        branching  = 1'b0;
        #2;
        rst_i = 1'b0;
        check_eq("rst2_first", imem_addr, 32'h0);
        tick();
        check_eq("rst2_next", imem_addr, 32'h4);
        check_eq("rst2_pc_if0", pc_if, 32'h0);
        // BTB contents cleared by reset
        fetch_check("rst2_btb", 32'h80, 32'h0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have ports (name direction width meaning):
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- imem_addr_if_o  out  32  instruction memory byte address (= current PC)
- imem_data_if_i  in  32  instruction word, combinational read of imem_addr_if_o
- load_stall_if_i  in  1  load-use stall from decode
- peripheral_stall_if_i  in  1  Wishbone peripheral stall
- branching_if_i  in  1  redirect request (mispredict / jump resolved in execute)
- branch_target_if_i  in  32  redirect PC
- btb_update_en_if_i  in  1  resolved control-transfer update strobe
- btb_update_pc_if_i  in  32  PC of the resolved instruction
- btb_update_target_if_i  in  32  resolved target
- btb_update_taken_if_i  in  1  resolved direction
- fetched_instruction_if_o  out  32  IF/ID instruction
- pc_if_o  out  32  IF/ID PC
- btb_predicted_pc_if_o  out  32  IF/ID predicted next PC
- branch_is_taken_prediction_if_o  out  1  IF/ID predicted direction

Function
REQ-002 SHALL hold the PC register pc_r; imem_addr_if_o = pc_r combinationally.
REQ-003 Next-PC priority SHALL be: branching_if_i -> branch_target_if_i; else stall (load_stall_if_i | peripheral_stall_if_i) -> pc_r held; else predicted taken -> BTB target; else pc_r + 4 (32-bit modular wrap).
REQ-004 The IF/ID register SHALL, on branching_if_i, load NOP 32'h0000_0013, pc_if_o = pc_r, predicted PC = pc_r + 4, taken = 0.
REQ-005 The IF/ID register SHALL hold all outputs on stall without branching_if_i.
REQ-006 In all other cycles, the IF/ID register SHALL load imem_data_if_i, pc_r, the predicted next PC, and the taken bit; fetch-to-decode latency is 1 cycle.
REQ-007 The BTB SHALL be 16-entry direct-mapped: index pc[5:2], tag pc[31:6], valid bit, 32-bit target, 2-bit saturating counter.
REQ-008 A prediction SHALL be taken iff valid & tag match & counter[1]; predicted PC = target when taken, else pc_r + 4.
REQ-009 On btb_update_en_if_i with a tag hit, the BTB SHALL increment (taken) or decrement (not taken) the counter, saturating at 3 and 0, and SHALL write the target only when taken.
REQ-010 On btb_update_en_if_i with a miss or invalid entry, the BTB SHALL allocate: valid = 1, tag written, target written, counter = 2'b10 if taken else 2'b01.
REQ-011 BTB updates SHALL occur regardless of stall or branching state.
REQ-012 A same-cycle lookup and update of one index SHALL return the pre-update contents (read-old).

Reset
REQ-013 On rst_i, all of the following SHALL take effect immediately: pc_r = 32'h0; fetched_instruction_if_o = 32'h0000_0013; pc_if_o = 32'hFFFF_FFFC; btb_predicted_pc_if_o = 32'h0; branch_is_taken_prediction_if_o = 0; all BTB valid bits = 0; all counters = 2'b01.
REQ-014 Reset asserted mid-stall or mid-redirect SHALL override everything; the first fetch after deassertion is address 0.

Configuration
REQ-015 With macro BRANCH_PREDICTION_EN defined, the BTB and predictor SHALL be instantiated per REQ-007..012.
REQ-016 Without BRANCH_PREDICTION_EN, the block SHALL have no BTB storage, taken SHALL be 0, predicted PC SHALL be pc_r + 4, and update inputs SHALL be ignored; the port list is unchanged.

Structure
REQ-017 The shared package SHALL hold NOP_INSTR (32'h0000_0013), RESET_PC (32'h0), BTB_ENTRIES (16), BTB_INDEX_W (4), and counter encodings (SNT/WNT/WT/ST).
REQ-018 The BTB SHALL be the sub-module branch_target_buffer (lookup port + update port); the PC and IF/ID register stay in instruction_fetch.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Reset, then release with straight-line code -> imem_addr 0, 4, 8; pc_if_o lags by 1 cycle; first pc_if_o after reset = 0xFFFF_FFFC.
- load_stall_if_i high for 2 cycles at pc 0x10 -> imem_addr stays 0x10; IF/ID outputs frozen; resumes at 0x14.
- branching_if_i with target 0x200 while peripheral_stall_if_i = 1 -> next pc_r = 0x200; IF/ID = NOP, taken = 0.
- Update pc 0x40 -> 0x100 taken (counter 10), then fetch 0x40 -> taken = 1, predicted 0x100, next imem_addr 0x100; two not-taken updates -> counter 00, predicts 0x44.
- Aliasing: entry for 0x40 valid, then fetch 0x80 (same index, different tag) -> not taken, predicted 0x84; update 0x80 replaces the entry.
- Build without BRANCH_PREDICTION_EN, same update stream as the fourth scenario -> taken always 0, predicted = pc + 4.
